tri_subdiv_ctrl: RTL and testbench

- Upstream feeder for the triangle bisector stage.
- Accepts one Triangle3D per handshake and recursively splits it along the longest edge by driving the bisect instance.
- Splitting is depth-first through an internal LIFO. A triangle stops splitting when its longest screen-space edge squared is ≤ MAX_EDGE_SQ, or when it reaches MAX_LEVEL.
- Terminal triangles go out to the rasterizer on a valid/ready port.

---
 rtl/tri_subdiv_ctrl_pkg.sv | 68 ++++++
 rtl/tri_stack.sv | 60 ++++++
 rtl/tri_subdiv_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_tri_subdiv_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_subdiv_ctrl_pkg.sv
// Shared types and helpers for the triangle subdivision controller.
//   Point3D / Triangle3D : unsigned 16-bit screen-space points and triangles
//   edge_sq_t            : 33-bit squared edge length (dx^2 + dy^2)
//   stack_entry_t        : triangle plus its bisection level, as kept in the LIFO
//   subdiv_state_t       : controller FSM states
//   edge_sq()            : squared screen-space length of one edge (z ignored)
//   longest_edge()       : 2-bit code of the longest edge, ties PQ > QR > RP
package tri_subdiv_ctrl_pkg;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
   } Point3D;

   typedef struct packed {
      Point3D p;
      Point3D q;
      Point3D r;
   } Triangle3D;

   typedef logic [32:0] edge_sq_t;

   typedef struct packed {
      Triangle3D   tri_data;
      logic [7:0]  level;
   } stack_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EVAL   = 3'd1,
      ST_SPLIT0 = 3'd2,
      ST_SPLIT1 = 3'd3,
      ST_SPLIT2 = 3'd4,
      ST_EMIT   = 3'd5
   } subdiv_state_t;

   localparam logic [1:0] EDGE_PQ = 2'd0;
   localparam logic [1:0] EDGE_QR = 2'd1;
   localparam logic [1:0] EDGE_RP = 2'd2;

   // Absolute differences are taken first so the squares stay unsigned 32-bit.
   function automatic edge_sq_t edge_sq(input Point3D a, input Point3D b);
      logic [15:0] dx;
      logic [15:0] dy;
      logic [31:0] sq_x;
      logic [31:0] sq_y;
      dx   = (a.x >= b.x) ? (a.x - b.x) : (b.x - a.x);
      dy   = (a.y >= b.y) ? (a.y - b.y) : (b.y - a.y);
      sq_x = 32'(dx) * 32'(dx);
      sq_y = 32'(dy) * 32'(dy);
      return edge_sq_t'(sq_x) + edge_sq_t'(sq_y);
   endfunction

   // Comparisons use >= so an equal earlier edge keeps priority.
   function automatic logic [1:0] longest_edge(input edge_sq_t pq,
                                               input edge_sq_t qr,
                                               input edge_sq_t rp);
      if ((pq >= qr) && (pq >= rp)) begin
         return EDGE_PQ;
      end
      if (qr >= rp) begin
         return EDGE_QR;
      end
      return EDGE_RP;
   endfunction

endpackage

// File: rtl/tri_stack.sv
// Parameterised LIFO holding pending triangle halves.
//   clk, rst   : clock, synchronous active-high reset (empties the stack)
//   push       : write push_data on top (ignored when full)
//   pop        : discard the top entry (ignored when empty)
//   top        : current top entry (undefined content when empty)
//   count      : number of valid entries
//   full/empty : occupancy flags
module tri_stack #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] top,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign top   = mem_q[IW'(count_q - 1'b1)];

   // Push wins if both are requested; the controller never asks for both.
   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      if (push && !full) begin
         mem_d[IW'(count_q)] = push_data;
         count_d             = count_q + 1'b1;
      end else if (pop && !empty) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries above count are never observed.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/tri_subdiv_ctrl.sv
// Triangle subdivision controller feeding an external longest-edge bisector.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake for tri_in
//   out_valid/out_ready : output handshake for terminal triangles on tri_out
//   bis_tri_in          : triangle to bisect, rotated so PQ is the longest edge
//   bis_tri_select      : 0 selects half (p,mid,r), 1 selects (mid,q,r)
//   bis_tri_out         : bisector result, one cycle after bis_tri_in/select
//   busy                : work in progress for the current input
//   done                : pulse on acceptance of the final output of a batch
//   out_count           : outputs accepted for the current input
module tri_subdiv_ctrl
   import tri_subdiv_ctrl_pkg::*;
#(
   parameter int       STACK_DEPTH = 8,
   parameter int       MAX_LEVEL   = 6,
   parameter edge_sq_t MAX_EDGE_SQ = 33'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  Triangle3D   tri_in,
   output logic        out_valid,
   input  logic        out_ready,
   output Triangle3D   tri_out,
   output Triangle3D   bis_tri_in,
   output logic        bis_tri_select,
   input  Triangle3D   bis_tri_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] out_count
);

   localparam int CW = $clog2(STACK_DEPTH + 1);

   subdiv_state_t state_q, state_d;
   Triangle3D     cur_q, cur_d;
   Triangle3D     hold_a_q, hold_a_d;
   logic [7:0]    level_q, level_d;
   logic [15:0]   out_count_q, out_count_d;

   stack_entry_t  push_entry;
   stack_entry_t  top_entry;
   logic [CW-1:0] stk_count;
   logic          stk_full;
   logic          stk_empty;
   logic          stk_push;
   logic          stk_pop;

   edge_sq_t      e_pq, e_qr, e_rp, max_sq;
   logic [1:0]    longest;
   Triangle3D     rotated;
   logic          is_terminal;
   logic          in_split;

   tri_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH ($bits(stack_entry_t))
   ) u_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (stk_push),
      .push_data (push_entry),
      .pop       (stk_pop),
      .top       (top_entry),
      .count     (stk_count),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   // Edge lengths of the current triangle and the rotation that puts the
   // longest edge in the PQ position expected by the bisector.
   always_comb begin
      e_pq    = edge_sq(cur_q.p, cur_q.q);
      e_qr    = edge_sq(cur_q.q, cur_q.r);
      e_rp    = edge_sq(cur_q.r, cur_q.p);
      longest = longest_edge(e_pq, e_qr, e_rp);
      case (longest)
         EDGE_QR: begin
            max_sq  = e_qr;
            rotated = {cur_q.q, cur_q.r, cur_q.p};
         end
         EDGE_RP: begin
            max_sq  = e_rp;
            rotated = {cur_q.r, cur_q.p, cur_q.q};
         end
         default: begin
            max_sq  = e_pq;
            rotated = cur_q;
         end
      endcase
      // A full stack forces termination so a later push can never overflow.
      is_terminal = (max_sq <= MAX_EDGE_SQ) ||
                    (level_q >= 8'(MAX_LEVEL)) ||
                    (stk_count == CW'(STACK_DEPTH));
   end

   // Second half of a split comes straight off the bisector in SPLIT2.
   always_comb begin
      push_entry.tri_data = bis_tri_out;
      push_entry.level    = level_q + 8'd1;
   end

   // Controller FSM: evaluate, split via the bisector (one half kept as cur,
   // the other pushed), and emit terminal triangles depth-first.
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      hold_a_d    = hold_a_q;
      level_d     = level_q;
      out_count_d = out_count_q;
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               cur_d       = tri_in;
               level_d     = '0;
               out_count_d = '0;
               state_d     = ST_EVAL;
            end
         end
         ST_EVAL: begin
            if (is_terminal) begin
               state_d = ST_EMIT;
            end else begin
               cur_d   = rotated;
               state_d = ST_SPLIT0;
            end
         end
         ST_SPLIT0: begin
            state_d = ST_SPLIT1;
         end
         ST_SPLIT1: begin
            hold_a_d = bis_tri_out;
            state_d  = ST_SPLIT2;
         end
         ST_SPLIT2: begin
            stk_push = !stk_full;
            cur_d    = hold_a_q;
            level_d  = level_q + 8'd1;
            state_d  = ST_EVAL;
         end
         ST_EMIT: begin
            if (out_ready) begin
               out_count_d = out_count_q + 16'd1;
               if (!stk_empty) begin
                  stk_pop = 1'b1;
                  cur_d   = top_entry.tri_data;
                  level_d = top_entry.level;
                  state_d = ST_EVAL;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cur_q       <= '0;
         hold_a_q    <= '0;
         level_q     <= '0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         hold_a_q    <= hold_a_d;
         level_q     <= level_d;
         out_count_q <= out_count_d;
      end
   end

   // cur_q only changes at the end of SPLIT2, so the bisector input stays
   // stable across all three split cycles.
   always_comb begin
      in_split       = (state_q == ST_SPLIT0) || (state_q == ST_SPLIT1) ||
                       (state_q == ST_SPLIT2);
      in_ready       = (state_q == ST_IDLE) && !rst;
      out_valid      = (state_q == ST_EMIT) && !rst;
      tri_out        = out_valid ? cur_q : '0;
      bis_tri_in     = in_split ? cur_q : '0;
      bis_tri_select = (state_q == ST_SPLIT1);
      busy           = (state_q != ST_IDLE);
      done           = out_valid && out_ready && stk_empty;
      out_count      = out_count_q;
   end

endmodule

// File: tb/tb_tri_subdiv_ctrl.sv
// Self-checking bench for tri_subdiv_ctrl. Four instances with different
// thresholds / depth limits share clock and reset; each has its own
// behavioural bisector. Expected outputs come from a queue-based reference
// model of the subdivision rules.
module tb_tri_subdiv_ctrl;
   import tri_subdiv_ctrl_pkg::*;

   localparam int     NI      = 4;
   localparam int     SD      = 8;
   localparam longint TH [NI] = '{64'd1000000, 64'd683797, 64'd683796, 64'd5000};
   localparam int     LV [NI] = '{6, 6, 6, 1};
   localparam int     LIMIT   = 20000;

   logic        clk;
   logic        rst;
   logic        in_valid  [NI];
   logic        in_ready  [NI];
   Triangle3D   tri_in    [NI];
   logic        out_valid [NI];
   logic        out_ready [NI];
   Triangle3D   tri_out   [NI];
   Triangle3D   bis_in    [NI];
   logic        bis_sel   [NI];
   Triangle3D   bis_out   [NI];
   logic        busy      [NI];
   logic        done      [NI];
   logic [15:0] out_count [NI];

   int          n_pass;
   int          n_total;
   int          n_fail;
   Triangle3D   exp_q[$];
   Triangle3D   got_q[$];
   int          exp_lat;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      tri_subdiv_ctrl #(
         .STACK_DEPTH (SD),
         .MAX_LEVEL   (LV[g]),
         .MAX_EDGE_SQ (33'(TH[g]))
      ) u_dut (
         .clk            (clk),
         .rst            (rst),
         .in_valid       (in_valid[g]),
         .in_ready       (in_ready[g]),
         .tri_in         (tri_in[g]),
         .out_valid      (out_valid[g]),
         .out_ready      (out_ready[g]),
         .tri_out        (tri_out[g]),
         .bis_tri_in     (bis_in[g]),
         .bis_tri_select (bis_sel[g]),
         .bis_tri_out    (bis_out[g]),
         .busy           (busy[g]),
         .done           (done[g]),
         .out_count      (out_count[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic Point3D pt(input int x, input int y, input int z);
      Point3D v;
      v.x = 16'(x);
      v.y = 16'(y);
      v.z = 16'(z);
      return v;
   endfunction

   function automatic Triangle3D tri3(input Point3D a, input Point3D b, input Point3D c);
      Triangle3D t;
      t.p = a;
      t.q = b;
      t.r = c;
      return t;
   endfunction

   function automatic Point3D midpoint(input Point3D a, input Point3D b);
      return pt((int'(a.x) + int'(b.x)) / 2, (int'(a.y) + int'(b.y)) / 2,
                (int'(a.z) + int'(b.z)) / 2);
   endfunction

   function automatic longint dist2(input Point3D a, input Point3D b);
      longint dx;
      longint dy;
      dx = longint'(a.x) - longint'(b.x);
      dy = longint'(a.y) - longint'(b.y);
      return dx * dx + dy * dy;
   endfunction

   // Behavioural bisector: registered, one cycle of latency.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (bis_sel[i]) begin
            bis_out[i] <= tri3(midpoint(bis_in[i].p, bis_in[i].q), bis_in[i].q, bis_in[i].r);
         end else begin
            bis_out[i] <= tri3(bis_in[i].p, midpoint(bis_in[i].p, bis_in[i].q), bis_in[i].r);
         end
      end
   end

   // Reference model: explicit work list, first half explored first.
   task automatic build_expected(input int idx, input Triangle3D t);
      Triangle3D work_t[$];
      int        work_l[$];
      Triangle3D c;
      Triangle3D r;
      Point3D    m;
      longint    e0, e1, e2, emax;
      int        lv;
      int        splits;
      bit        seen;
      exp_q.delete();
      work_t.push_back(t);
      work_l.push_back(0);
      splits = 0;
      seen   = 1'b0;
      while (work_t.size() > 0) begin
         c  = work_t.pop_back();
         lv = work_l.pop_back();
         e0 = dist2(c.p, c.q);
         e1 = dist2(c.q, c.r);
         e2 = dist2(c.r, c.p);
         if (e0 >= e1 && e0 >= e2) begin
            emax = e0;
            r    = c;
         end else if (e1 >= e2) begin
            emax = e1;
            r    = tri3(c.q, c.r, c.p);
         end else begin
            emax = e2;
            r    = tri3(c.r, c.p, c.q);
         end
         if (emax <= TH[idx] || lv >= LV[idx] || work_t.size() == SD) begin
            exp_q.push_back(c);
            seen = 1'b1;
         end else begin
            if (!seen) splits++;
            m = midpoint(r.p, r.q);
            work_t.push_back(tri3(m, r.q, r.r));
            work_l.push_back(lv + 1);
            work_t.push_back(tri3(r.p, m, r.r));
            work_l.push_back(lv + 1);
         end
      end
      exp_lat = 2 + 4 * splits;
   endtask

   task automatic checkOutput(input string tag, input logic [143:0] obs, input logic [143:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Sends one triangle to instance idx and follows it to completion.
   // mode 0: out_ready always 1; mode 1: random; mode 2: first 5 valid cycles stalled.
   task automatic applyStimulus(input int idx, input Triangle3D t, input int mode);
      int k;
      int cyc;
      int hold;
      bit got_first;
      build_expected(idx, t);
      got_q.delete();
      @(posedge clk); #1;
      checkOutput("in_ready_idle", in_ready[idx], 1'b1);
      in_valid[idx] = 1'b1;
      tri_in[idx]   = t;
      @(posedge clk); #1;
      in_valid[idx] = 1'b0;
      tri_in[idx]   = '0;
      k         = 0;
      cyc       = 0;
      hold      = 0;
      got_first = 1'b0;
      while (k < exp_q.size() && cyc < LIMIT) begin
         cyc++;
         case (mode)
            0:       out_ready[idx] = 1'b1;
            1:       out_ready[idx] = 1'($urandom_range(0, 1));
            default: out_ready[idx] = (hold >= 5);
         endcase
         #1;
         if (out_valid[idx]) begin
            if (!got_first) begin
               checkOutput("first_latency", cyc, exp_lat);
               got_first = 1'b1;
            end
            checkOutput("tri_out", tri_out[idx], exp_q[k]);
            checkOutput("out_count_run", out_count[idx], k);
            checkOutput("in_ready_busy", in_ready[idx], 1'b0);
            checkOutput("busy_run", busy[idx], 1'b1);
            if (out_ready[idx]) begin
               checkOutput("done_pulse", done[idx], (k == exp_q.size() - 1));
               got_q.push_back(tri_out[idx]);
               k++;
            end else begin
               checkOutput("done_stalled", done[idx], 1'b0);
               hold++;
            end
         end
         @(posedge clk); #1;
      end
      checkOutput("all_outputs_seen", k, exp_q.size());
      out_ready[idx] = 1'b1;
      #1;
      checkOutput("busy_end", busy[idx], 1'b0);
      checkOutput("out_count_end", out_count[idx], exp_q.size());
      checkOutput("out_valid_end", out_valid[idx], 1'b0);
      checkOutput("in_ready_end", in_ready[idx], 1'b1);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      Triangle3D base;
      Triangle3D tie;
      Triangle3D rt;
      n_pass  = 0;
      n_total = 0;
      n_fail  = 0;
      for (int i = 0; i < NI; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b1;
         tri_in[i]    = '0;
      end
      base = tri3(pt(115, 56, 0), pt(346, 850, 0), pt(310, 450, 0));
      tie  = tri3(pt(0, 0, 0), pt(10, 0, 0), pt(5, 100, 0));

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in_ready_low", in_ready[0], 1'b0);
      checkOutput("rst_out_valid", out_valid[0], 1'b0);
      checkOutput("rst_busy", busy[0], 1'b0);
      checkOutput("rst_done", done[0], 1'b0);
      checkOutput("rst_out_count", out_count[0], 16'd0);
      checkOutput("rst_tri_out", tri_out[0], 144'd0);
      checkOutput("rst_bis_in", bis_in[0], 144'd0);
      checkOutput("rst_bis_sel", bis_sel[0], 1'b0);
      rst = 1'b0;
      #1;
      checkOutput("rst_release_in_ready", in_ready[0], 1'b1);

      // Threshold 1e6: no split, output equals input
      applyStimulus(0, base, 0);
      checkOutput("nosplit_count", got_q.size(), 1);
      checkOutput("nosplit_tri", got_q[0], base);

      // Threshold equal to PQ^2, with 5 stalled EMIT cycles
      applyStimulus(1, base, 2);
      checkOutput("boundary_count", got_q.size(), 1);
      checkOutput("boundary_tri", got_q[0], base);

      // Threshold one below PQ^2: single split
      applyStimulus(2, base, 0);
      checkOutput("split_count", got_q.size(), 2);
      checkOutput("split_a", got_q[0], tri3(pt(115, 56, 0), pt(230, 453, 0), pt(310, 450, 0)));
      checkOutput("split_b", got_q[1], tri3(pt(230, 453, 0), pt(346, 850, 0), pt(310, 450, 0)));

      // QR/RP tie resolved to QR
      applyStimulus(3, tie, 0);
      checkOutput("tie_count", got_q.size(), 2);
      checkOutput("tie_a", got_q[0], tri3(pt(10, 0, 0), pt(7, 50, 0), pt(0, 0, 0)));
      checkOutput("tie_b", got_q[1], tri3(pt(7, 50, 0), pt(5, 100, 0), pt(0, 0, 0)));

      // Reset while the bisector is producing the second half
      @(posedge clk); #1;
      in_valid[2] = 1'b1;
      tri_in[2]   = base;
      @(posedge clk); #1;
      in_valid[2] = 1'b0;
      tri_in[2]   = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("split1_sel", bis_sel[2], 1'b1);
      checkOutput("split1_bis_in", bis_in[2], base);
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("midrst_out_valid", out_valid[2], 1'b0);
      checkOutput("midrst_busy", busy[2], 1'b0);
      checkOutput("midrst_count", out_count[2], 16'd0);
      checkOutput("midrst_bis_sel", bis_sel[2], 1'b0);
      checkOutput("midrst_bis_in", bis_in[2], 144'd0);
      checkOutput("midrst_in_ready", in_ready[2], 1'b0);
      rst = 1'b0;
      #1;
      checkOutput("midrst_release", in_ready[2], 1'b1);
      applyStimulus(0, base, 0);
      checkOutput("post_rst_count", got_q.size(), 1);
      checkOutput("post_rst_tri", got_q[0], base);
      applyStimulus(2, base, 1);
      checkOutput("post_rst_split_count", got_q.size(), 2);

      // Randomised triangles against the reference model
      for (int n = 0; n < 12; n++) begin
         rt = tri3(pt($urandom_range(0, 3000), $urandom_range(0, 3000), $urandom_range(0, 65535)),
                   pt($urandom_range(0, 3000), $urandom_range(0, 3000), $urandom_range(0, 65535)),
                   pt($urandom_range(0, 3000), $urandom_range(0, 3000), $urandom_range(0, 65535)));
         applyStimulus(2, rt, 1);
      end
      for (int n = 0; n < 8; n++) begin
         rt = tri3(pt($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535)),
                   pt($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535)),
                   pt($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535)));
         applyStimulus(3, rt, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
